// File: rtl/inst_defs.sv
// inst_defs: shared fetch-stage macros and the inst_fetch_pkg package.
// The FAULT state is only reachable when MISALIGN_CHK_EN is defined.
`ifndef INST_DEFS_SV
`define INST_DEFS_SV
`define PC_RANGE 31:0
`define INST_RANGE 31:0
`define PC_STEP 32'd4
`define RESET_PC_DEFAULT 32'h0000_0000
`endif

package inst_fetch_pkg;
    typedef enum logic {RUN, FAULT} fetch_state_e;
    localparam logic [`PC_RANGE] PC_STEP = `PC_STEP;
    localparam logic [`PC_RANGE] RESET_PC_DEFAULT = `RESET_PC_DEFAULT;
endpackage

// File: rtl/inst_fetch_fifo.sv
// inst_fetch_fifo: instruction buffer of {pc, inst} entries with synchronous flush.
module inst_fetch_fifo #(
    parameter int BUF_DEPTH = 2,
    localparam int AW = $clog2(BUF_DEPTH),
    localparam int CW = AW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush_i,
    input  logic          push_i,
    input  logic [63:0]   data_i,
    input  logic          pop_i,
    output logic [63:0]   data_o,
    output logic [CW-1:0] count_o
);
    logic [63:0]   mem_q [BUF_DEPTH];
    logic [AW-1:0] rd_q, wr_q;
    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (reset || flush_i) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_i) wr_q <= wr_q + AW'(1);
            if (pop_i) rd_q <= rd_q + AW'(1);
            cnt_q <= cnt_q + CW'(push_i) - CW'(pop_i);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < BUF_DEPTH; i++) mem_q[i] <= '0;
        end else if (push_i && !flush_i) begin
            mem_q[wr_q] <= data_i;
        end
    end

    assign data_o  = mem_q[rd_q];
    assign count_o = cnt_q;
endmodule

// File: rtl/inst_fetch.sv
// inst_fetch: PC, credit-limited imem requests, response buffer and redirect flush.
// Define MISALIGN_CHK_EN to trap misaligned redirects in a FAULT state.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        fetch_fault
);
    localparam int CW = $clog2(BUF_DEPTH) + 1;
    localparam int LW = CW + 2;

    logic [31:0]   pc_q, pc_d, rpc_q, rpc_d, tgt;
    logic [CW-1:0] out_q, out_d, drop_q, drop_d, count;
    logic [LW-1:0] live;
    logic [63:0]   head;
    logic          fire, deq, push, flush, fault;

`ifdef MISALIGN_CHK_EN
    fetch_state_e state_q, state_d;
    assign tgt = redirect_pc;
    always_comb begin
        state_d = redirect_valid ? ((redirect_pc[1:0] != 2'b00) ? FAULT : RUN) : state_q;
    end
    always_ff @(posedge clk) begin
        state_q <= reset ? RUN : state_d;
    end
    assign fault = state_q == FAULT;
`else
    assign tgt   = redirect_pc & ~32'h3;
    assign fault = 1'b0;
`endif

    always_comb begin
        deq  = inst_valid && inst_ready;
        live = LW'(out_q) - LW'(drop_q) + LW'(count) - LW'(deq);
        // out_q != '1 keeps the in-flight counter from wrapping under back-to-back redirects
        imem_req_valid = !reset && !redirect_valid && !fault && live < LW'(BUF_DEPTH) && out_q != '1;
        fire   = imem_req_valid && imem_req_ready;
        push   = imem_resp_valid && drop_q == '0 && !redirect_valid && !fault;
        flush  = redirect_valid || fault;
        out_d  = out_q + CW'(fire) - CW'(imem_resp_valid);
        drop_d = redirect_valid ? out_d : drop_q - CW'(imem_resp_valid && drop_q != '0);
        pc_d   = redirect_valid ? tgt : fire ? pc_q + PC_STEP : pc_q;
        // rpc_q is the PC of the next live response, which arrives in request order
        rpc_d  = redirect_valid ? tgt : push ? rpc_q + PC_STEP : rpc_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q   <= RESET_PC;
            rpc_q  <= RESET_PC;
            out_q  <= '0;
            drop_q <= '0;
        end else begin
            pc_q   <= pc_d;
            rpc_q  <= rpc_d;
            out_q  <= out_d;
            drop_q <= drop_d;
        end
    end

    inst_fetch_fifo #(.BUF_DEPTH(BUF_DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .flush_i (flush),
        .push_i  (push),
        .data_i  ({rpc_q, imem_resp_data}),
        .pop_i   (deq),
        .data_o  (head),
        .count_o (count)
    );

    assign imem_req_addr = pc_q;
    assign inst_valid    = count != '0;
    assign inst_pc       = head[63:32];
    assign inst          = head[31:0];
    assign fetch_fault   = fault;
endmodule
